// File: rtl/fc_layer_mac_if.sv
// Handshake and data bundle for fc_layer_mac: vector in, neuron results out.
// Widths follow the layer geometry parameters of the instance.
interface fc_layer_mac_if #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 2,
    parameter int WEIGHT_BITS = 8,
    parameter int ACTIV_BITS  = 8
);
    logic                                       in_valid;
    logic                                       in_ready;
    logic [INPUT_SIZE*ACTIV_BITS-1:0]           input_data;
    logic [INPUT_SIZE*OUTPUT_SIZE*WEIGHT_BITS-1:0] weights;
    logic [OUTPUT_SIZE*ACTIV_BITS-1:0]          biases;
    logic [4:0]                                 shift;
    logic                                       relu_en;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [OUTPUT_SIZE*ACTIV_BITS-1:0]          output_data;
    logic                                       sat_flag;

    modport master (
        output in_valid, input_data, weights, biases, shift, relu_en, out_ready,
        input  in_ready, out_valid, output_data, sat_flag
    );

    modport slave (
        input  in_valid, input_data, weights, biases, shift, relu_en, out_ready,
        output in_ready, out_valid, output_data, sat_flag
    );
endinterface

// File: rtl/fc_layer_mac.sv
// Time-multiplexed fully connected layer: one signed MAC per cycle, then bias,
// requantising shift, optional ReLU and saturation per output neuron.
module fc_layer_mac #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 2,
    parameter int WEIGHT_BITS = 8,
    parameter int ACTIV_BITS  = 8,
    parameter int ACC_BITS    = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    fc_layer_mac_if.slave  bus,
    output logic           busy
);
    localparam int IW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
    localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PW = WEIGHT_BITS + ACTIV_BITS;
    localparam logic [IW-1:0] LAST_I = IW'(INPUT_SIZE - 1);
    localparam logic [OW-1:0] LAST_O = OW'(OUTPUT_SIZE - 1);

    typedef logic signed [ACC_BITS-1:0] acc_t;
    localparam acc_t SAT_MAX = acc_t'(2**(ACTIV_BITS-1) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2**(ACTIV_BITS-1)));

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                                       state_q, state_d;
    logic [INPUT_SIZE*ACTIV_BITS-1:0]             x_q, x_d;
    logic [INPUT_SIZE*OUTPUT_SIZE*WEIGHT_BITS-1:0] w_q, w_d;
    logic [OUTPUT_SIZE*ACTIV_BITS-1:0]            b_q, b_d;
    logic [4:0]                                   shift_q, shift_d;
    logic                                         relu_q, relu_d;
    acc_t                                         acc_q, acc_d;
    logic [IW-1:0]                                i_q, i_d;
    logic [OW-1:0]                                o_q, o_d;
    logic [OUTPUT_SIZE*ACTIV_BITS-1:0]            y_q, y_d;
    logic                                         sat_q, sat_d;

    logic signed [ACTIV_BITS-1:0]  x_cur;
    logic signed [WEIGHT_BITS-1:0] w_cur;
    logic signed [PW-1:0]          prod;
    acc_t                          sum, shifted, clamped;
    logic [ACTIV_BITS-1:0]         y_val;
    logic                          clip;

    always_comb begin
        x_cur   = x_q[int'(i_q)*ACTIV_BITS +: ACTIV_BITS];
        w_cur   = w_q[(int'(o_q)*INPUT_SIZE + int'(i_q))*WEIGHT_BITS +: WEIGHT_BITS];
        prod    = x_cur * w_cur;
        sum     = acc_q + acc_t'(prod);
        shifted = sum >>> shift_q;
        clamped = (relu_q && shifted < 0) ? '0 : shifted;
        // ReLU runs before the clip so a zeroed negative never counts as saturation
        clip    = 1'b0;
        y_val   = clamped[ACTIV_BITS-1:0];
        if (clamped > SAT_MAX) begin
            y_val = SAT_MAX[ACTIV_BITS-1:0];
            clip  = 1'b1;
        end else if (clamped < SAT_MIN) begin
            y_val = SAT_MIN[ACTIV_BITS-1:0];
            clip  = 1'b1;
        end

        state_d = state_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        i_d     = i_q;
        o_d     = o_q;
        y_d     = y_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.input_data;
                    w_d     = bus.weights;
                    b_d     = bus.biases;
                    shift_d = bus.shift;
                    relu_d  = bus.relu_en;
                    acc_d   = acc_t'(signed'(bus.biases[ACTIV_BITS-1:0]));
                    i_d     = '0;
                    o_d     = '0;
                    sat_d   = 1'b0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (i_q == LAST_I) begin
                    y_d[int'(o_q)*ACTIV_BITS +: ACTIV_BITS] = y_val;
                    if (clip) sat_d = 1'b1;
                    if (o_q == LAST_O) begin
                        state_d = DONE;
                    end else begin
                        o_d   = o_q + OW'(1);
                        i_d   = '0;
                        acc_d = acc_t'(signed'(b_q[(int'(o_q)+1)*ACTIV_BITS +: ACTIV_BITS]));
                    end
                end else begin
                    acc_d = sum;
                    i_d   = i_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            i_q     <= '0;
            o_q     <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            w_q     <= w_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            o_q     <= o_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.output_data = y_q;
    assign bus.sat_flag    = sat_q;
    assign busy            = (state_q != IDLE);
endmodule
